pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the datapath. It holds the current instruction address and drives it onto the bus. It supports absolute load, increment by a configurable step, PC-relative branch, and, optionally, call/return through a small hardware return-address stack (RAS). All updates are registered on the rising clock edge; the unit sits where the single-register PC sits today and exposes the same bus-facing ports.

## Interface
- WIDTH, 32, address width in bits (≥ 8)
- RESET_VAL, 0, PC value loaded by reset (WIDTH bits)
- STEP, 1, increment applied by incPC and used for call return address (WIDTH bits, unsigned)
- RAS_DEPTH, 4, return-address stack entries (≥ 1; used only with PC_RAS_EN)

Ports:
- clock  in  1  single clock, rising edge
- clear_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze: PC, stack and flags hold
- enable  in  1  absolute load: PC ← BusMuxOut
- call  in  1  push PC+STEP, then PC ← BusMuxOut
- ret  in  1  PC ← top of stack, pop
- incPC  in  1  PC ← PC + STEP
- branch  in  1  PC ← PC + BusMuxOut (two's-complement offset)
- BusMuxOut  in  WIDTH  target address or branch offset
- BusMuxIn  out  WIDTH  current PC (registered)
- ras_count  out  $clog2(RAS_DEPTH+1)  valid stack entries
- ras_err  out  1  sticky stack overflow/underflow flag

## Operation
- Priority per edge (highest first): clear_n low, stall, enable, call, ret, incPC, branch. Only the highest asserted command acts; lower commands that edge are ignored entirely (no push, no pop).
- No command asserted: PC holds.
- Arithmetic is modulo 2^WIDTH. 0xFFFF_FFFF + STEP(1) wraps to 0; a branch offset of 0xFFFF_FFFC subtracts 4.
- RAS is a circular buffer with top pointer and saturating count:
  - Push on call when count < RAS_DEPTH: count+1.
  - Push on call when count == RAS_DEPTH: the oldest entry is overwritten, count stays RAS_DEPTH, ras_err ← 1.
  - Pop on ret when count > 0: PC ← top entry, count−1.
  - Pop on ret when count == 0: PC ← PC + STEP (treated as incPC), stack unchanged, ras_err ← 1.
- ras_err stays 1 until reset; no other clear.
- Stack entry contents are not reset. After reset they are don't-care, and only ras_count determines validity.

## Timing
- Reset (clear_n low, asynchronous, no clock needed): BusMuxIn = RESET_VAL, ras_count = 0, ras_err = 0. These hold while clear_n is low, and commands are ignored.
- Reset deassertion: the first edge with clear_n high may execute a command.
- Latency is 1 cycle: a command sampled at edge N is visible on BusMuxIn, ras_count and ras_err after edge N.
- BusMuxIn is a pure register output with no combinational path from inputs.
- call followed by ret on the next cycle returns to the call-site PC + STEP; back-to-back is legal with no bubble.
- stall high: every state element holds, including across asserted commands.
- Reset mid-sequence (e.g. between call and ret): stack is emptied (count 0), and a subsequent ret is an underflow.

## Configuration
- PC_RAS_EN defined: RAS, ras_count and ras_err are implemented as above.
- PC_RAS_EN undefined:
  - No stack storage is built, and RAS_DEPTH is ignored.
  - call behaves as enable (PC ← BusMuxOut, no push).
  - ret behaves as incPC.
  - ras_count and ras_err are tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset/increment: RESET_VAL=0x100, STEP=4. Pulse clear_n low mid-clock, then incPC for 3 cycles. BusMuxIn is 0x100 immediately on reset (asynchronous), then 0x104, 0x108, 0x10C.
- Priority/stall: PC=0x10, assert enable (BusMuxOut=0x200), incPC and branch together, so PC=0x200. Then assert stall with incPC, so PC stays 0x200.
- Branch wrap: PC=0x8, branch with BusMuxOut=0xFFFF_FFF8, so PC=0x0. Then PC=0xFFFF_FFFF with incPC (STEP=1), so PC=0x0.
- Nested call/return (RAS_DEPTH=4, STEP=1):
  - From PC=0x10, call 0x40; from 0x40, call 0x80. ras_count goes 1 then 2.
  - ret gives PC=0x41; ret again gives PC=0x11.
  - ras_count=0 and ras_err=0.
- Overflow/underflow (RAS_DEPTH=2, STEP=1):
  - Call three times: from PC=0x1 to target 0x10, from 0x10 to 0x20, from 0x20 to 0x30. Then ras_count=2 and ras_err=1.
  - Two rets give PC 0x21, then 0x11.
  - A third ret gives PC=0x12 and count stays 0.
  - ras_err stays 1 until clear_n is pulsed.
- PC_RAS_EN undefined: call with BusMuxOut=0x500 gives PC=0x500, then ret gives PC=0x501. ras_count=0 and ras_err=0 throughout.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter register for the datapath.
//
// Holds the current instruction address and drives it onto the bus. Each rising
// edge applies at most one command, highest priority first:
//   stall > enable > call > ret > incPC > branch
// With PC_RAS_EN defined, call/ret use a circular return-address stack
// (RAS_DEPTH entries, saturating count, sticky overflow/underflow flag).
// With PC_RAS_EN undefined, call acts as enable, ret acts as incPC, and
// ras_count/ras_err are tied to zero.
//
// Ports:
//   clock      in   rising-edge clock
//   clear_n    in   asynchronous active-low reset
//   stall      in   hold all state
//   enable     in   PC <- BusMuxOut
//   call       in   push PC+STEP, PC <- BusMuxOut
//   ret        in   PC <- top of stack, pop (empty stack: PC+STEP, flag error)
//   incPC      in   PC <- PC+STEP
//   branch     in   PC <- PC+BusMuxOut (two's-complement offset)
//   BusMuxOut  in   target address / branch offset
//   BusMuxIn   out  current PC (registered)
//   ras_count  out  valid stack entries
//   ras_err    out  sticky overflow/underflow flag
module pc_unit #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter logic [WIDTH-1:0]  STEP      = WIDTH'(1),
    parameter int unsigned       RAS_DEPTH = 4,
    localparam int unsigned      CW        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             stall,
    input  logic             enable,
    input  logic             call,
    input  logic             ret,
    input  logic             incPC,
    input  logic             branch,
    input  logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] BusMuxIn,
    output logic [CW-1:0]    ras_count,
    output logic             ras_err
);

    logic [WIDTH-1:0] pc_q, pc_d;

`ifdef PC_RAS_EN
    localparam int unsigned   PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);

    // wr_q is the slot the next push writes; the top entry sits one below it.
    // When the stack is full, wr_q lands on the oldest entry, so a push there
    // overwrites it naturally.
    logic [WIDTH-1:0] stk_q [RAS_DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAS_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? PW'(RAS_DEPTH - 1) : p - PW'(1);
    endfunction

    always_comb begin
        pc_d  = pc_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        push  = 1'b0;
        if (!stall) begin
            if (enable) begin
                pc_d = BusMuxOut;
            end else if (call) begin
                push = 1'b1;
                wr_d = ptr_inc(wr_q);
                pc_d = BusMuxOut;
                if (cnt_q == FULL) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (ret) begin
                if (cnt_q != '0) begin
                    wr_d  = ptr_dec(wr_q);
                    pc_d  = stk_q[ptr_dec(wr_q)];
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Underflow falls back to a plain increment.
                    pc_d  = pc_q + STEP;
                    err_d = 1'b1;
                end
            end else if (incPC) begin
                pc_d = pc_q + STEP;
            end else if (branch) begin
                pc_d = pc_q + BusMuxOut;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pc_q  <= RESET_VAL;
            wr_q  <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Stack contents are never reset; ras_count alone marks validity.
    always_ff @(posedge clock) begin
        if (clear_n && push) begin
            stk_q[wr_q] <= pc_q + STEP;
        end
    end

    assign ras_count = cnt_q;
    assign ras_err   = err_q;
`else
    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            if (enable || call) begin
                pc_d = BusMuxOut;
            end else if (ret || incPC) begin
                pc_d = pc_q + STEP;
            end else if (branch) begin
                pc_d = pc_q + BusMuxOut;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pc_q <= RESET_VAL;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign ras_count = '0;
    assign ras_err   = 1'b0;
`endif

    assign BusMuxIn = pc_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    logic        clock = 1'b0;
    logic        clear_n = 1'b1;
    logic        stall = 1'b0, enable = 1'b0, call = 1'b0, ret = 1'b0;
    logic        incPC = 1'b0, branch = 1'b0;
    logic [31:0] bus = '0;

    logic [31:0] pc_a, pc_b;
    logic [2:0]  cnt_a;
    logic [1:0]  cnt_b;
    logic        err_a, err_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    // Instance A: RESET_VAL=0x100, STEP=4, depth 4.
    pc_unit #(.WIDTH(32), .RESET_VAL(32'h100), .STEP(32'd4), .RAS_DEPTH(4)) u_a (
        .clock(clock), .clear_n(clear_n), .stall(stall), .enable(enable),
        .call(call), .ret(ret), .incPC(incPC), .branch(branch),
        .BusMuxOut(bus), .BusMuxIn(pc_a), .ras_count(cnt_a), .ras_err(err_a));

    // Instance B: RESET_VAL=0, STEP=1, depth 2.
    pc_unit #(.WIDTH(32), .RESET_VAL(32'h0), .STEP(32'd1), .RAS_DEPTH(2)) u_b (
        .clock(clock), .clear_n(clear_n), .stall(stall), .enable(enable),
        .call(call), .ret(ret), .incPC(incPC), .branch(branch),
        .BusMuxOut(bus), .BusMuxIn(pc_b), .ras_count(cnt_b), .ras_err(err_b));

    logic [31:0] dut_pc [2];
    logic [2:0]  dut_cnt [2];
    logic        dut_err [2];
    assign dut_pc[0]  = pc_a;
    assign dut_pc[1]  = pc_b;
    assign dut_cnt[0] = cnt_a;
    assign dut_cnt[1] = {1'b0, cnt_b};
    assign dut_err[0] = err_a;
    assign dut_err[1] = err_b;

    // Reference model: PC value, a queue standing for the stack (back = top),
    // and the sticky error bit, per instance.
    logic [31:0] m_pc [2];
    logic [31:0] m_stk [2][$];
    bit          m_err [2];
    logic [31:0] m_step [2];
    logic [31:0] m_rst [2];
    int          m_depth [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = m_rst[k];
            m_err[k] = 1'b0;
            m_stk[k].delete();
        end
    endtask

    task automatic model_edge();
        if (!clear_n) return;
        for (int k = 0; k < 2; k++) begin
            if (stall) continue;
            if (enable) begin
                m_pc[k] = bus;
            end else if (call) begin
`ifdef PC_RAS_EN
                if (m_stk[k].size() == m_depth[k]) begin
                    void'(m_stk[k].pop_front());
                    m_err[k] = 1'b1;
                end
                m_stk[k].push_back(m_pc[k] + m_step[k]);
`endif
                m_pc[k] = bus;
            end else if (ret) begin
`ifdef PC_RAS_EN
                if (m_stk[k].size() > 0) begin
                    m_pc[k] = m_stk[k].pop_back();
                end else begin
                    m_pc[k]  = m_pc[k] + m_step[k];
                    m_err[k] = 1'b1;
                end
`else
                m_pc[k] = m_pc[k] + m_step[k];
`endif
            end else if (incPC) begin
                m_pc[k] = m_pc[k] + m_step[k];
            end else if (branch) begin
                m_pc[k] = m_pc[k] + bus;
            end
        end
    endtask

    task automatic drive(input logic st, input logic en, input logic cl, input logic rt,
                         input logic inc, input logic br, input logic [31:0] b);
        stall = st; enable = en; call = cl; ret = rt; incPC = inc; branch = br; bus = b;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        drive(0, 0, 0, 0, 0, 0, '0);
    endtask

    // Async reset pulse away from the clock edge, held across two edges with
    // commands asserted, released on a falling edge.
    task automatic pulse_reset();
        @(negedge clock);
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        drive(0, 1, 1, 0, 1, 1, 32'h1234);
        @(posedge clock);
        @(posedge clock);
        #1;
        drive(0, 0, 0, 0, 0, 0, '0);
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        #2;
        clear_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pc_a !== 32'h100 || pc_b !== 32'h0) begin
            failures++;
            $display("FAIL reset_async pc_a=%h pc_b=%h exp 100/0", pc_a, pc_b);
        end
        drive(0, 1, 1, 1, 1, 1, 32'hABCD);
        @(posedge clock);
        @(posedge clock);
        #1;
        checks++;
        if (pc_a !== 32'h100 || pc_b !== 32'h0 || cnt_a !== 3'd0 || cnt_b !== 2'd0 ||
            err_a !== 1'b0 || err_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold pc_a=%h pc_b=%h cnt=%0d/%0d err=%b/%b exp 100/0 0/0 0/0",
                     pc_a, pc_b, cnt_a, cnt_b, err_a, err_b);
        end
        drive(0, 0, 0, 0, 0, 0, '0);
        @(negedge clock);
        clear_n = 1'b1;
    endtask

    task automatic test_increment();
        logic [31:0] exp_a;
        exp_a = 32'h100;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, '0);
            tick();
            exp_a = exp_a + 32'd4;
            checks++;
            if (pc_a !== exp_a || pc_b !== 32'(i)) begin
                failures++;
                $display("FAIL increment_%0d pc_a=%h pc_b=%h exp %h/%h", i, pc_a, pc_b, exp_a, i);
            end
        end
    endtask

    task automatic test_priority_stall();
        drive(0, 1, 0, 0, 0, 0, 32'h10); tick();
        drive(0, 1, 0, 0, 1, 1, 32'h200); tick();
        checks++;
        if (pc_a !== 32'h200 || pc_b !== 32'h200) begin
            failures++;
            $display("FAIL prio_enable pc_a=%h pc_b=%h exp 200", pc_a, pc_b);
        end
        drive(1, 0, 0, 0, 1, 0, '0); tick();
        checks++;
        if (pc_a !== 32'h200 || pc_b !== 32'h200) begin
            failures++;
            $display("FAIL stall_inc pc_a=%h pc_b=%h exp 200", pc_a, pc_b);
        end
        drive(1, 1, 1, 1, 1, 1, 32'h777); tick();
        checks++;
        if (pc_a !== 32'h200 || pc_b !== 32'h200 || cnt_a !== 3'd0 || err_b !== 1'b0) begin
            failures++;
            $display("FAIL stall_all pc_a=%h pc_b=%h cnt_a=%0d err_b=%b exp 200 0 0",
                     pc_a, pc_b, cnt_a, err_b);
        end
        // call outranks ret/incPC/branch; ret outranks incPC/branch.
        drive(0, 0, 1, 1, 1, 1, 32'h340); tick();
        drive(0, 0, 0, 1, 1, 1, 32'h8); tick();
        drive(0, 0, 0, 0, 1, 1, 32'h8); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_pc[k] !== m_pc[k] || dut_cnt[k] !== 3'(m_stk[k].size()) || dut_err[k] !== m_err[k]) begin
                failures++;
                $display("FAIL prio_model[%0d] pc=%h cnt=%0d err=%b exp %h %0d %b",
                         k, dut_pc[k], dut_cnt[k], dut_err[k], m_pc[k], m_stk[k].size(), m_err[k]);
            end
        end
    endtask

    task automatic test_branch_wrap();
        drive(0, 1, 0, 0, 0, 0, 32'h8); tick();
        drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFF8); tick();
        checks++;
        if (pc_a !== 32'h0 || pc_b !== 32'h0) begin
            failures++;
            $display("FAIL branch_wrap pc_a=%h pc_b=%h exp 0", pc_a, pc_b);
        end
        drive(0, 1, 0, 0, 0, 0, 32'hFFFF_FFFF); tick();
        drive(0, 0, 0, 0, 1, 0, '0); tick();
        checks++;
        if (pc_b !== 32'h0 || pc_a !== 32'h3) begin
            failures++;
            $display("FAIL inc_wrap pc_a=%h pc_b=%h exp 3/0", pc_a, pc_b);
        end
        drive(0, 1, 0, 0, 0, 0, 32'h100); tick();
        drive(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC); tick();
        checks++;
        if (pc_a !== 32'hFC || pc_b !== 32'hFC) begin
            failures++;
            $display("FAIL branch_neg pc_a=%h pc_b=%h exp fc", pc_a, pc_b);
        end
    endtask

    task automatic test_nested_call();
        logic [31:0] e_r1, e_r2;
        logic [1:0]  e_c1, e_c2;
`ifdef PC_RAS_EN
        e_r1 = 32'h41; e_r2 = 32'h11; e_c1 = 2'd1; e_c2 = 2'd2;
`else
        e_r1 = 32'h81; e_r2 = 32'h82; e_c1 = 2'd0; e_c2 = 2'd0;
`endif
        pulse_reset();
        drive(0, 1, 0, 0, 0, 0, 32'h10); tick();
        drive(0, 0, 1, 0, 0, 0, 32'h40); tick();
        checks++;
        if (pc_b !== 32'h40 || cnt_b !== e_c1) begin
            failures++;
            $display("FAIL nest_call1 pc=%h cnt=%0d exp 40 %0d", pc_b, cnt_b, e_c1);
        end
        drive(0, 0, 1, 0, 0, 0, 32'h80); tick();
        checks++;
        if (pc_b !== 32'h80 || cnt_b !== e_c2) begin
            failures++;
            $display("FAIL nest_call2 pc=%h cnt=%0d exp 80 %0d", pc_b, cnt_b, e_c2);
        end
        drive(0, 0, 0, 1, 0, 0, '0); tick();
        checks++;
        if (pc_b !== e_r1) begin
            failures++;
            $display("FAIL nest_ret1 pc=%h exp %h", pc_b, e_r1);
        end
        drive(0, 0, 0, 1, 0, 0, '0); tick();
        checks++;
        if (pc_b !== e_r2 || cnt_b !== 2'd0 || err_b !== 1'b0) begin
            failures++;
            $display("FAIL nest_ret2 pc=%h cnt=%0d err=%b exp %h 0 0", pc_b, cnt_b, err_b, e_r2);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_pc[k] !== m_pc[k] || dut_cnt[k] !== 3'(m_stk[k].size()) || dut_err[k] !== m_err[k]) begin
                failures++;
                $display("FAIL nest_model[%0d] pc=%h cnt=%0d err=%b exp %h %0d %b",
                         k, dut_pc[k], dut_cnt[k], dut_err[k], m_pc[k], m_stk[k].size(), m_err[k]);
            end
        end
    endtask

    task automatic test_overflow_underflow();
        logic [31:0] e_r [3];
        logic [1:0]  e_cnt;
        logic        e_err;
`ifdef PC_RAS_EN
        e_r[0] = 32'h21; e_r[1] = 32'h11; e_r[2] = 32'h12; e_cnt = 2'd2; e_err = 1'b1;
`else
        e_r[0] = 32'h31; e_r[1] = 32'h32; e_r[2] = 32'h33; e_cnt = 2'd0; e_err = 1'b0;
`endif
        pulse_reset();
        drive(0, 1, 0, 0, 0, 0, 32'h1); tick();
        drive(0, 0, 1, 0, 0, 0, 32'h10); tick();
        drive(0, 0, 1, 0, 0, 0, 32'h20); tick();
        drive(0, 0, 1, 0, 0, 0, 32'h30); tick();
        checks++;
        if (pc_b !== 32'h30 || cnt_b !== e_cnt || err_b !== e_err) begin
            failures++;
            $display("FAIL overflow pc=%h cnt=%0d err=%b exp 30 %0d %b", pc_b, cnt_b, err_b, e_cnt, e_err);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 0, 0, '0); tick();
            checks++;
            if (pc_b !== e_r[i] || err_b !== e_err) begin
                failures++;
                $display("FAIL unwind_%0d pc=%h err=%b exp %h %b", i, pc_b, err_b, e_r[i], e_err);
            end
        end
        checks++;
        if (cnt_b !== 2'd0) begin
            failures++;
            $display("FAIL underflow_cnt cnt=%0d exp 0", cnt_b);
        end
        drive(0, 0, 0, 0, 1, 0, '0); tick();
        drive(0, 1, 0, 0, 0, 0, 32'h5); tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_pc[k] !== m_pc[k] || dut_cnt[k] !== 3'(m_stk[k].size()) || dut_err[k] !== m_err[k]) begin
                failures++;
                $display("FAIL sticky_model[%0d] pc=%h cnt=%0d err=%b exp %h %0d %b",
                         k, dut_pc[k], dut_cnt[k], dut_err[k], m_pc[k], m_stk[k].size(), m_err[k]);
            end
        end
        pulse_reset();
        checks++;
        if (err_b !== 1'b0 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%b/%b exp 0/0", err_a, err_b);
        end
    endtask

    task automatic test_back_to_back();
        drive(0, 1, 0, 0, 0, 0, 32'h20); tick();
        drive(0, 0, 1, 0, 0, 0, 32'h300); tick();
        drive(0, 0, 0, 1, 0, 0, '0); tick();
`ifdef PC_RAS_EN
        checks++;
        if (pc_a !== 32'h24 || pc_b !== 32'h21 || cnt_a !== 3'd0) begin
            failures++;
            $display("FAIL back_to_back pc_a=%h pc_b=%h cnt=%0d exp 24/21 0", pc_a, pc_b, cnt_a);
        end
`else
        checks++;
        if (pc_a !== 32'h304 || pc_b !== 32'h301) begin
            failures++;
            $display("FAIL back_to_back pc_a=%h pc_b=%h exp 304/301", pc_a, pc_b);
        end
`endif
    endtask

    task automatic test_reset_mid_sequence();
        drive(0, 1, 0, 0, 0, 0, 32'h10); tick();
        drive(0, 0, 1, 0, 0, 0, 32'h40); tick();
        pulse_reset();
        drive(0, 0, 0, 1, 0, 0, '0); tick();
        checks++;
        if (pc_a !== 32'h104 || pc_b !== 32'h1 || cnt_a !== 3'd0 || cnt_b !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid pc_a=%h pc_b=%h cnt=%0d/%0d exp 104/1 0/0", pc_a, pc_b, cnt_a, cnt_b);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_err[k] !== m_err[k]) begin
                failures++;
                $display("FAIL reset_mid_err[%0d] err=%b exp %b", k, dut_err[k], m_err[k]);
            end
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : 32'($urandom));
            tick();
            if ($urandom_range(0, 59) == 0) begin
                clear_n = 1'b0;
                model_reset();
                #1;
                clear_n = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (dut_pc[k] !== m_pc[k] || dut_cnt[k] !== 3'(m_stk[k].size()) || dut_err[k] !== m_err[k]) begin
                    failures++;
                    $display("FAIL random_%0d[%0d] pc=%h cnt=%0d err=%b exp %h %0d %b",
                             n, k, dut_pc[k], dut_cnt[k], dut_err[k], m_pc[k], m_stk[k].size(), m_err[k]);
                end
            end
        end
    endtask

    initial begin
        m_step[0] = 32'd4;   m_step[1] = 32'd1;
        m_rst[0]  = 32'h100; m_rst[1]  = 32'h0;
        m_depth[0] = 4;      m_depth[1] = 2;
        model_reset();
        test_reset();
        test_increment();
        test_priority_stall();
        test_branch_wrap();
        test_nested_call();
        test_overflow_underflow();
        test_back_to_back();
        test_reset_mid_sequence();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
